// File: rtl/df_fir_sequencer_if.sv
// df_fir_sequencer_if: sample/result handshakes, coefficient write port and busy flag
interface df_fir_sequencer_if;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       coef_we;
  logic [2:0] coef_addr;
  logic [1:0] coef_wdata;
  logic       busy;
  modport master (
    output in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    input  in_ready, out_valid, out_data, busy
  );
  modport slave (
    input  in_valid, in_data, out_ready, coef_we, coef_addr, coef_wdata,
    output in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/df_fir_sequencer.sv
// df_fir_sequencer: time-multiplexed FIR over one shared multiplier; DF_SEQ_SATURATE_EN clamps out_data at 255
module df_multiplier_c1 (
  input  logic [7:0] data,
  input  logic [1:0] code,
  output logic [7:0] prod
);
  logic [10:0] full;
  assign full = {3'b0, data} + (code[0] ? {2'b0, data, 1'b0} : 11'd0) + (code[1] ? {1'b0, data, 2'b0} : 11'd0);
  assign prod = full[10:3];
endmodule

module df_fir_sequencer #(
  parameter int TAPS = 4
) (
  input logic clk,
  input logic rst,
  df_fir_sequencer_if.slave bus
);
  localparam int KW = $clog2(TAPS);
  localparam int ACC_W = 8 + KW;
  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;
  state_t state, state_n;
  logic [7:0] delay [TAPS];
  logic [1:0] shadow [TAPS];
  logic [1:0] active [TAPS];
  logic [KW-1:0] k;
  logic [ACC_W-1:0] acc;
  logic [7:0] prod;
  logic accept, last;
  assign accept = (state == IDLE) && bus.in_valid;
  assign last = k == KW'(TAPS - 1);
  df_multiplier_c1 u_mult (.data(delay[k]), .code(active[k]), .prod(prod));
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    state_n = accept ? MAC :
              (state == MAC && last) ? OUT :
              (state == OUT && bus.out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        delay[i] <= '0;
        shadow[i] <= '0;
        active[i] <= '0;
      end
      k <= '0;
      acc <= '0;
    end else begin
      if (bus.coef_we && 32'(bus.coef_addr) < TAPS) shadow[bus.coef_addr[KW-1:0]] <= bus.coef_wdata;
      if (accept) begin
        delay[0] <= bus.in_data;
        for (int i = 1; i < TAPS; i++) delay[i] <= delay[i-1];
        // a shadow write landing on the accepting edge is taken straight into the active bank
        for (int i = 0; i < TAPS; i++)
          active[i] <= (bus.coef_we && 32'(bus.coef_addr) == i) ? bus.coef_wdata : shadow[i];
        acc <= '0;
        k <= '0;
      end else if (state == MAC) begin
        acc <= acc + ACC_W'(prod);
        k <= k + 1'b1;
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == OUT;
  assign bus.busy = state != IDLE;
`ifdef DF_SEQ_SATURATE_EN
  assign bus.out_data = (acc > ACC_W'(255)) ? 8'hFF : acc[7:0];
`else
  assign bus.out_data = acc[7:0];
`endif
endmodule

// File: tb/tb_df_fir_sequencer.sv
// tb_df_fir_sequencer: scoreboard-driven bench for df_fir_sequencer
module tb_df_fir_sequencer;
  localparam int TAPS = 4;
  logic clk = 0;
  logic rst = 1;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  df_fir_sequencer_if bus ();
  df_fir_sequencer #(.TAPS(TAPS)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic [7:0] d;
    int a;
    bit lat;
  } exp_t;
  exp_t q[$];

  // results are taken on the edge after a negedge that sees valid&ready, so each is popped once
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus.out_valid && bus.out_ready) begin
      total++;
      if (q.size() == 0) $display("FAIL unexpected_out: got out_data=%0d, required no result", bus.out_data);
      else begin
        e = q.pop_front();
        if (bus.out_data !== e.d) $display("FAIL out_data: got %0d, required %0d", bus.out_data, e.d);
        else if (e.lat && cyc - e.a != TAPS) $display("FAIL latency: got %0d edges, required %0d", cyc - e.a, TAPS);
        else passed++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic [7:0] exp_d, input bit push, input bit lat,
                      input bit we = 0, input logic [2:0] a = 0, input logic [1:0] c = 0);
    int n = 0;
    while (!bus.in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!bus.in_ready) begin
      total++;
      $display("FAIL send_timeout: in_ready=0, required 1");
      return;
    end
    bus.in_valid = 1;
    bus.in_data = d;
    bus.coef_we = we;
    bus.coef_addr = a;
    bus.coef_wdata = c;
    tick();
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.coef_we = 0;
    if (push) q.push_back('{exp_d, cyc, lat});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || !bus.in_ready) && n < 200) begin
      tick();
      n++;
    end
    if (q.size() != 0 || !bus.in_ready) begin
      total++;
      $display("FAIL drain_timeout: pending=%0d in_ready=%0d, required 0 and 1", q.size(), bus.in_ready);
    end
  endtask

  task automatic wr_coef(input logic [2:0] a, input logic [1:0] c);
    bus.coef_we = 1;
    bus.coef_addr = a;
    bus.coef_wdata = c;
    tick();
    bus.coef_we = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic test_reset();
    total++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", bus.in_ready); else passed++;
    total++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", bus.out_valid); else passed++;
    total++;
    if (bus.out_data !== 8'd0) $display("FAIL reset_out_data: got %0d, required 0", bus.out_data); else passed++;
    total++;
    if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", bus.busy); else passed++;
  endtask

  task automatic test_impulse();
    logic [7:0] smp [5] = '{8'h80, 8'h00, 8'h00, 8'h00, 8'h00};
    logic [7:0] exp [5] = '{8'd16, 8'd48, 8'd80, 8'd112, 8'd0};
    for (int i = 0; i < 4; i++) wr_coef(3'(i), 2'(i));
    for (int i = 0; i < 5; i++) begin
      send(smp[i], exp[i], 1, 1);
      if (i == 0) begin
        total++;
        if (bus.busy !== 1'b1 || bus.in_ready !== 1'b0)
          $display("FAIL mac_busy: got busy=%b in_ready=%b, required 1 and 0", bus.busy, bus.in_ready);
        else passed++;
      end
    end
    wait_idle();
  endtask

  task automatic test_overflow();
`ifdef DF_SEQ_SATURATE_EN
    logic [7:0] exp [4] = '{8'd223, 8'd255, 8'd255, 8'd255};
`else
    logic [7:0] exp [4] = '{8'd223, 8'd190, 8'd157, 8'd124};
`endif
    for (int i = 0; i < 4; i++) wr_coef(3'(i), 2'd3);
    for (int i = 0; i < 4; i++) send(8'hFF, exp[i], 1, 1);
    wait_idle();
  endtask

  task automatic test_backpressure();
    int n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) wr_coef(3'(i), 2'(i));
    bus.out_ready = 0;
    send(8'h80, 8'd16, 1, 0);
    while (!bus.out_valid && n < 50) begin
      tick();
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      total++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 8'd16 || bus.in_ready !== 1'b0)
        $display("FAIL backpressure_hold: got valid=%b data=%0d in_ready=%b, required 1 16 0",
                 bus.out_valid, bus.out_data, bus.in_ready);
      else passed++;
      bus.in_valid = (i == 3);
      bus.in_data = 8'h55;
      tick();
    end
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.out_ready = 1;
    wait_idle();
    send(8'h00, 8'd48, 1, 1);
    wait_idle();
  endtask

  task automatic test_coef_timing();
    do_reset();
    send(8'h80, 8'd16, 1, 1);
    wr_coef(3'd0, 2'd3);
    wait_idle();
    send(8'h80, 8'd128, 1, 1);
    wait_idle();
    send(8'h00, 8'd128, 1, 1, 1, 3'd1, 2'd3);
    wait_idle();
  endtask

  task automatic test_reset_mid_mac();
    do_reset();
    send(8'h80, 8'd0, 0, 0);
    tick();
    rst = 1;
    tick();
    test_reset();
    rst = 0;
    send(8'h80, 8'd16, 1, 1);
    wait_idle();
  endtask

  task automatic test_out_of_range();
    logic [7:0] smp [4] = '{8'h80, 8'h00, 8'h00, 8'h00};
    do_reset();
    wr_coef(3'd5, 2'd3);
    for (int i = 0; i < 4; i++) send(smp[i], 8'd16, 1, 1);
    wait_idle();
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_data = 0;
    bus.out_ready = 1;
    bus.coef_we = 0;
    bus.coef_addr = 0;
    bus.coef_wdata = 0;
    repeat (3) tick();
    rst = 0;
    test_reset();
    test_impulse();
    test_overflow();
    test_backpressure();
    test_coef_timing();
    test_reset_mid_mac();
    test_out_of_range();
    repeat (10) tick();
    total++;
    if (q.size() != 0) $display("FAIL leftover: got %0d pending results, required 0", q.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
